// File: rtl/lab5_mcore_arb_pkg.sv
// Shared types for the main-memory arbiter: port tags and 16B memory messages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lab5_mcore_arb_pkg;

    localparam logic c_port_imem = 1'b0;
    localparam logic c_port_dmem = 1'b1;

    // Which port issued an outstanding request.
    typedef logic arb_tag_t;

    // 16B memory request: type, opaque, address, length, data.
    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    // 16B memory response: type, opaque, test bits, length, data.
    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

endpackage

// File: rtl/lab5_mcore_arb_tag_fifo.sv
// In-order FIFO of 1-bit source tags, one entry per outstanding memory request.
// Latency: a pushed tag is visible at head on the next cycle; head/full/empty come straight from flops.
// Backpressure: a push while full or a pop while empty is ignored; full is registered, so a same-cycle pop never makes room for a push.
// Ports: clk, reset (async active-low), push/push_tag, pop, full, empty, head.
module lab5_mcore_arb_tag_fifo
    import lab5_mcore_arb_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  arb_tag_t push_tag,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output arb_tag_t head
);

    localparam int c_ptr_w = $clog2(p_depth);

    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w:0]   count_q,  count_d;
    logic [p_depth-1:0] slots_q,  slots_d;

    logic push_ok;
    logic pop_ok;

    assign full  = (count_q == (c_ptr_w + 1)'(p_depth));
    assign empty = (count_q == '0);
    assign head  = slots_q[rd_ptr_q];

    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        slots_d  = slots_q;
        if (push_ok) begin
            slots_d[wr_ptr_q] = push_tag;
            // Depth is a power of two, so the pointer wraps by overflow.
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            slots_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            slots_q  <= slots_d;
        end
    end

endmodule

// File: rtl/lab5_mcore_main_mem_arb.sv
// Merges the imem and dmem 16B memory ports onto one main-memory port (round-robin), routing in-order responses back by source tag.
// Latency: 0 cycles on both request and response paths (pure combinational pass-through).
// Backpressure: no buffering; requests stall when memreq_rdy is low or p_max_inflight are outstanding; responses stall on the owning port's rdy.
// Ports: clk, reset (async active-low); imemreq/dmemreq in; imemresp/dmemresp out; memreq out; memresp in.
// Optional macro ARB_STATS_EN adds grant_cnt[1:0][31:0] and conflict_cnt[31:0] statistics outputs.
module lab5_mcore_main_mem_arb
    import lab5_mcore_arb_pkg::*;
#(
    parameter int p_max_inflight = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  mem_req_16B_t  imemreq_msg,
    input  logic          imemreq_val,
    output logic          imemreq_rdy,
    output mem_resp_16B_t imemresp_msg,
    output logic          imemresp_val,
    input  logic          imemresp_rdy,

    input  mem_req_16B_t  dmemreq_msg,
    input  logic          dmemreq_val,
    output logic          dmemreq_rdy,
    output mem_resp_16B_t dmemresp_msg,
    output logic          dmemresp_val,
    input  logic          dmemresp_rdy,

    output mem_req_16B_t  memreq_msg,
    output logic          memreq_val,
    input  logic          memreq_rdy,
    input  mem_resp_16B_t memresp_msg,
    input  logic          memresp_val,
    output logic          memresp_rdy
`ifdef ARB_STATS_EN
    ,
    output logic [1:0][31:0] grant_cnt,
    output logic [31:0]      conflict_cnt
`endif
);

    arb_tag_t last_grant_q, last_grant_d;
    arb_tag_t sel;
    arb_tag_t head;
    logic     both_val;
    logic     any_val;
    logic     fire;
    logic     pop;
    logic     full;
    logic     empty;

    // Arbitration: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        both_val = imemreq_val & dmemreq_val;
        any_val  = imemreq_val | dmemreq_val;
        if (both_val) begin
            sel = ~last_grant_q;
        end else if (dmemreq_val) begin
            sel = c_port_dmem;
        end else begin
            sel = c_port_imem;
        end
    end

    // Handshakes are gated by reset so nothing looks valid or ready while it is held.
    always_comb begin
        memreq_msg  = (sel == c_port_dmem) ? dmemreq_msg : imemreq_msg;
        memreq_val  = reset & any_val & ~full;
        imemreq_rdy = reset & memreq_rdy & ~full & (sel == c_port_imem);
        dmemreq_rdy = reset & memreq_rdy & ~full & (sel == c_port_dmem);
        fire        = memreq_val & memreq_rdy;
        last_grant_d = fire ? sel : last_grant_q;
    end

    // Responses arrive strictly in request order, so the FIFO head names the owner.
    always_comb begin
        imemresp_msg = memresp_msg;
        dmemresp_msg = memresp_msg;
        imemresp_val = reset & memresp_val & ~empty & (head == c_port_imem);
        dmemresp_val = reset & memresp_val & ~empty & (head == c_port_dmem);
        memresp_rdy  = reset & ~empty & ((head == c_port_dmem) ? dmemresp_rdy : imemresp_rdy);
        pop          = memresp_val & memresp_rdy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= c_port_dmem;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    lab5_mcore_arb_tag_fifo #(
        .p_depth (p_max_inflight)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fire),
        .push_tag (sel),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

`ifdef ARB_STATS_EN
    logic [1:0][31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0]      conflict_cnt_q, conflict_cnt_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        grant_cnt_d    = grant_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (fire) begin
            grant_cnt_d[sel] = grant_cnt_q[sel] + 32'd1;
        end
        if (both_val) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt    = grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_lab5_mcore_main_mem_arb.sv
// Testbench for lab5_mcore_main_mem_arb: directed scenarios followed by random traffic against a queue-based reference model.
// Latency: each step settles inputs, compares combinational outputs, then advances one clock.
// Backpressure: memory and response-port readiness are driven by the bench.
module tb_lab5_mcore_main_mem_arb;
    import lab5_mcore_arb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_req_16B_t  imemreq_msg, dmemreq_msg, memreq_msg;
    mem_resp_16B_t imemresp_msg, dmemresp_msg, memresp_msg;
    logic imemreq_val, imemreq_rdy, imemresp_val, imemresp_rdy;
    logic dmemreq_val, dmemreq_rdy, dmemresp_val, dmemresp_rdy;
    logic memreq_val, memreq_rdy, memresp_val, memresp_rdy;
`ifdef ARB_STATS_EN
    logic [1:0][31:0] grant_cnt;
    logic [31:0]      conflict_cnt;
    int unsigned      m_grant [2];
    int unsigned      m_conf;
`endif

    lab5_mcore_main_mem_arb #(.p_max_inflight(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .imemreq_msg  (imemreq_msg),
        .imemreq_val  (imemreq_val),
        .imemreq_rdy  (imemreq_rdy),
        .imemresp_msg (imemresp_msg),
        .imemresp_val (imemresp_val),
        .imemresp_rdy (imemresp_rdy),
        .dmemreq_msg  (dmemreq_msg),
        .dmemreq_val  (dmemreq_val),
        .dmemreq_rdy  (dmemreq_rdy),
        .dmemresp_msg (dmemresp_msg),
        .dmemresp_val (dmemresp_val),
        .dmemresp_rdy (dmemresp_rdy),
        .memreq_msg   (memreq_msg),
        .memreq_val   (memreq_val),
        .memreq_rdy   (memreq_rdy),
        .memresp_msg  (memresp_msg),
        .memresp_val  (memresp_val),
        .memresp_rdy  (memresp_rdy)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding owners in order, the requests memory still owes, and who was served last.
    bit           tags [$];
    mem_req_16B_t memq [$];
    bit           last_grant;
    bit           e_fire, e_pop, e_sel, e_both;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic mem_req_16B_t mk_req(input logic [31:0] addr);
        mem_req_16B_t r;
        r.msg_type = 3'($urandom_range(0, 1));
        r.opaque   = 8'($urandom);
        r.addr     = addr;
        r.len      = 4'($urandom);
        r.data     = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    function automatic mem_resp_16B_t resp_for(input mem_req_16B_t r);
        mem_resp_16B_t s;
        s.msg_type = r.msg_type;
        s.opaque   = r.opaque;
        s.test     = 2'b00;
        s.len      = r.len;
        s.data     = {r.addr, ~r.addr, r.data[63:0]};
        return s;
    endfunction

    task automatic drive_resp();
        if (memq.size() > 0) begin
            memresp_msg = resp_for(memq[0]);
        end else begin
            memresp_msg = resp_for(mk_req($urandom));
        end
    endtask

    // Let the combinational paths settle, then compare every output against the model.
    task automatic settle();
        bit full, empty, head, anyv, sel;
        bit ev_req, e_irdy, e_drdy, e_ival, e_dval, e_mrdy;
        #2;
        if (!reset) begin
            tags.delete();
            memq.delete();
            last_grant = 1'b1;
`ifdef ARB_STATS_EN
            m_grant[0] = 0;
            m_grant[1] = 0;
            m_conf     = 0;
`endif
        end
        full   = (tags.size() == DEPTH);
        empty  = (tags.size() == 0);
        head   = empty ? 1'b0 : tags[0];
        anyv   = imemreq_val || dmemreq_val;
        e_both = imemreq_val && dmemreq_val;
        // Lone requester wins; on a tie, the port that was not served most recently.
        sel    = e_both ? !last_grant : dmemreq_val;
        ev_req = reset && anyv && !full;
        e_irdy = reset && !full && memreq_rdy && !sel;
        e_drdy = reset && !full && memreq_rdy && sel;
        e_ival = reset && memresp_val && !empty && !head;
        e_dval = reset && memresp_val && !empty && head;
        e_mrdy = reset && !empty && (head ? dmemresp_rdy : imemresp_rdy);
        chk("memreq_val",   192'(memreq_val),   192'(ev_req));
        chk("imemreq_rdy",  192'(imemreq_rdy),  192'(e_irdy));
        chk("dmemreq_rdy",  192'(dmemreq_rdy),  192'(e_drdy));
        chk("imemresp_val", 192'(imemresp_val), 192'(e_ival));
        chk("dmemresp_val", 192'(dmemresp_val), 192'(e_dval));
        chk("memresp_rdy",  192'(memresp_rdy),  192'(e_mrdy));
        chk("imemresp_msg", 192'(imemresp_msg), 192'(memresp_msg));
        chk("dmemresp_msg", 192'(dmemresp_msg), 192'(memresp_msg));
        if (ev_req) begin
            chk("memreq_msg", 192'(memreq_msg), 192'(sel ? dmemreq_msg : imemreq_msg));
        end
`ifdef ARB_STATS_EN
        chk("grant_cnt0",   192'(grant_cnt[0]), 192'(m_grant[0]));
        chk("grant_cnt1",   192'(grant_cnt[1]), 192'(m_grant[1]));
        chk("conflict_cnt", 192'(conflict_cnt), 192'(m_conf));
`endif
        e_fire = ev_req && memreq_rdy;
        e_pop  = e_mrdy && memresp_val;
        e_sel  = sel;
    endtask

    // Commit the cycle's transfers into the model and step to just after the next rising edge.
    task automatic advance();
        if (reset) begin
            if (e_pop) begin
                void'(tags.pop_front());
                void'(memq.pop_front());
            end
            if (e_fire) begin
                tags.push_back(e_sel);
                memq.push_back(e_sel ? dmemreq_msg : imemreq_msg);
                last_grant = e_sel;
`ifdef ARB_STATS_EN
                m_grant[e_sel]++;
`endif
            end
`ifdef ARB_STATS_EN
            if (e_both) m_conf++;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        imemreq_val  = 1'b0;
        dmemreq_val  = 1'b0;
        memresp_val  = 1'b0;
        memreq_rdy   = 1'b1;
        imemresp_rdy = 1'b1;
        dmemresp_rdy = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        imemreq_msg = '0;
        dmemreq_msg = '0;
        memresp_msg = '0;
        idle_inputs();

        // Reset state: nothing valid or ready.
        settle();
        chk("rst_memreq_val",  192'(memreq_val),  192'(0));
        chk("rst_imemreq_rdy", 192'(imemreq_rdy), 192'(0));
        chk("rst_memresp_rdy", 192'(memresp_rdy), 192'(0));
        advance();
        cyc();
        reset = 1'b1;

        // 1: lone imem read at 0x1000, then its response.
        imemreq_msg          = mk_req(32'h1000);
        imemreq_msg.msg_type = 3'd0;
        imemreq_val          = 1'b1;
        settle();
        chk("t1_irdy", 192'(imemreq_rdy), 192'(1));
        chk("t1_msg",  192'(memreq_msg),  192'(imemreq_msg));
        advance();
        imemreq_val      = 1'b0;
        memresp_val      = 1'b1;
        drive_resp();
        memresp_msg.data = 128'hCAFE;
        settle();
        chk("t1_ival",  192'(imemresp_val),      192'(1));
        chk("t1_dval",  192'(dmemresp_val),      192'(0));
        chk("t1_idata", 192'(imemresp_msg.data), 192'(128'hCAFE));
        advance();

        // 2: both ports request for 6 cycles, memory answers one cycle later.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            imemreq_msg = mk_req(32'h2000 + 32'(i));
            dmemreq_msg = mk_req(32'h3000 + 32'(i));
            imemreq_val = (i < 6);
            dmemreq_val = (i < 6);
            memresp_val = (memq.size() > 0);
            drive_resp();
            settle();
            if (i < 6) begin
                chk("t2_grant", 192'(memreq_msg.addr),
                    192'((i % 2 == 0) ? (32'h2000 + 32'(i)) : (32'h3000 + 32'(i))));
            end
            if (i > 0 && i < 7) begin
                chk("t2_route_i", 192'(imemresp_val), 192'(i % 2 == 1));
                chk("t2_route_d", 192'(dmemresp_val), 192'(i % 2 == 0));
            end
            advance();
        end

        // 3: fill to depth with dmem requests; a pop while full does not admit a push that cycle.
        do_reset();
        dmemreq_val = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            dmemreq_msg = mk_req(32'h4000 + 32'(i));
            settle();
            chk("t3_fill", 192'(memreq_val), 192'(1));
            advance();
        end
        dmemreq_msg = mk_req(32'h4100);
        settle();
        chk("t3_full_val", 192'(memreq_val),  192'(0));
        chk("t3_full_rdy", 192'(dmemreq_rdy), 192'(0));
        advance();
        memresp_val = 1'b1;
        drive_resp();
        settle();
        chk("t3_pop_rdy",  192'(memresp_rdy), 192'(1));
        chk("t3_pop_hold", 192'(memreq_val),  192'(0));
        advance();
        memresp_val = 1'b0;
        settle();
        chk("t3_refire",     192'(memreq_val),  192'(1));
        chk("t3_refire_rdy", 192'(dmemreq_rdy), 192'(1));
        advance();

        // 4: drain, then queue imem then dmem and stall the imem response port.
        dmemreq_val = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            memresp_val = (memq.size() > 0);
            drive_resp();
            cyc();
        end
        memresp_val = 1'b0;
        chk("t4_drained", 192'(tags.size()), 192'(0));
        imemreq_msg = mk_req(32'h5000);
        imemreq_val = 1'b1;
        cyc();
        imemreq_val = 1'b0;
        dmemreq_msg = mk_req(32'h6000);
        dmemreq_val = 1'b1;
        cyc();
        dmemreq_val  = 1'b0;
        memresp_val  = 1'b1;
        imemresp_rdy = 1'b0;
        dmemresp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_resp();
            settle();
            chk("t4_mrdy", 192'(memresp_rdy),  192'(0));
            chk("t4_dval", 192'(dmemresp_val), 192'(0));
            chk("t4_ival", 192'(imemresp_val), 192'(1));
            advance();
        end

        // 5: reset with two outstanding; afterwards empty and imem wins the first conflict.
        imemreq_val  = 1'b1;
        dmemreq_val  = 1'b1;
        imemresp_rdy = 1'b1;
        reset        = 1'b0;
        settle();
        chk("t5_memreq_val", 192'(memreq_val),   192'(0));
        chk("t5_irdy",       192'(imemreq_rdy),  192'(0));
        chk("t5_drdy",       192'(dmemreq_rdy),  192'(0));
        chk("t5_mrdy",       192'(memresp_rdy),  192'(0));
        chk("t5_ival",       192'(imemresp_val), 192'(0));
        chk("t5_dval",       192'(dmemresp_val), 192'(0));
        advance();
        reset       = 1'b1;
        memresp_val = 1'b1;
        imemreq_msg = mk_req(32'h7000);
        dmemreq_msg = mk_req(32'h8000);
        drive_resp();
        settle();
        chk("t5_empty_rdy", 192'(memresp_rdy),     192'(0));
        chk("t5_grant",     192'(memreq_msg.addr), 192'(32'h7000));
        advance();
        memresp_val = 1'b0;

`ifdef ARB_STATS_EN
        // 6: ten conflict cycles at full throughput.
        do_reset();
        imemreq_val = 1'b1;
        dmemreq_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            imemreq_msg = mk_req($urandom);
            dmemreq_msg = mk_req($urandom);
            memresp_val = (memq.size() > 0);
            drive_resp();
            cyc();
        end
        imemreq_val = 1'b0;
        dmemreq_val = 1'b0;
        memresp_val = 1'b0;
        settle();
        chk("t6_conflict", 192'(conflict_cnt), 192'(10));
        chk("t6_grant0",   192'(grant_cnt[0]), 192'(5));
        chk("t6_grant1",   192'(grant_cnt[1]), 192'(5));
        advance();
`endif

        // Random traffic, including unexpected responses while empty.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            imemreq_val  = ($urandom_range(0, 99) < 60);
            dmemreq_val  = ($urandom_range(0, 99) < 60);
            imemreq_msg  = mk_req($urandom);
            dmemreq_msg  = mk_req($urandom);
            memreq_rdy   = ($urandom_range(0, 99) < 70);
            memresp_val  = ($urandom_range(0, 99) < 50);
            imemresp_rdy = ($urandom_range(0, 99) < 70);
            dmemresp_rdy = ($urandom_range(0, 99) < 70);
            drive_resp();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
